jtag_id_reader: RTL and testbench
=================================

Name: jtag_id_reader

Overview:
JTAG host-side initiator that reads the identification register out of an attached TAP target. A START pulse makes it drive TCK/TMS/TDI through the TAP state sequence Test-Logic-Reset → Run-Test/Idle → Shift-DR → Run-Test/Idle, sampling TDO. It returns the ID_WIDTH-bit ID word with a validity flag. It is the board/test-side counterpart of our TAP-side device ID shift register and is used in bring-up and self-test to confirm the chain responds.

Parameters:
ID_WIDTH, 8, number of ID bits shifted out of the target, captured LSB first; legal range 2..32.
HALF_PERIOD, 2, CLK cycles per TCK half period, giving a TCK period of 2*HALF_PERIOD CLK cycles; legal range ≥1.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST  input  1  asynchronous, active-high reset.
START  input  1  one-cycle request to run a read; sampled only while BUSY=0.
TDO  input  1  serial data from the target.
TCK  output  1  generated JTAG clock; idles low.
TMS  output  1  JTAG mode select.
TDI  output  1  JTAG data to the target; held 1 at all times after reset.
ID  output  ID_WIDTH  last captured ID word; bit 0 is the first bit sampled.
ID_VALID  output  1  equals captured ID[0]==1, per the IEEE IDCODE marker bit; updated together with ID.
BUSY  output  1  high while a sequence is in progress.
DONE  output  1  one-cycle pulse when ID/ID_VALID are updated.

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=1, ID=0, ID_VALID=0, BUSY=0, DONE=0. Internal FSM goes to IDLE and counters clear.
- Reset mid-sequence aborts immediately. No partial ID is written, and no DONE is produced.
- FSM states: IDLE, RUN, FINISH.
- IDLE: START=1 → RUN. BUSY goes to 1 on the next cycle, and the first TMS value is driven in that same cycle.
- RUN: steps through N = 11+ID_WIDTH TCK periods.
  - Each period is HALF_PERIOD cycles with TCK low, then HALF_PERIOD cycles with TCK high.
  - TMS changes only on the CLK cycle where TCK falls, or at sequence start.
  - TDO is sampled on the CLK cycle where TCK rises.
- TMS per TCK rising edge k (1-based):
  - k=1..5: TMS=1 (Test-Logic-Reset).
  - k=6: TMS=0 (Run-Test/Idle).
  - k=7: TMS=1 (Select-DR).
  - k=8: TMS=0 (Capture-DR).
  - k=9: TMS=0 (Shift-DR).
  - k=10..9+ID_WIDTH: shift edges. TMS=0, except TMS=1 on the last one (Exit1-DR).
  - k=10+ID_WIDTH: TMS=1 (Update-DR).
  - k=11+ID_WIDTH: TMS=0 (Run-Test/Idle).
- Capture: on shift edges the sampled TDO enters a shift register from the MSB side and shifts right. After ID_WIDTH samples, the first bit is in bit 0. Only shift edges sample; TDO on all other edges is ignored.
- FINISH: entered on the falling edge that ends period N.
  - Same cycle: ID ← shift register, ID_VALID ← shift register bit 0, DONE=1, BUSY=0.
  - Next cycle: DONE=0, FSM in IDLE.
  - Timing: DONE is high for exactly one cycle, (11+ID_WIDTH)*2*HALF_PERIOD+1 CLK cycles after the cycle START was sampled. This is 77 cycles with the defaults.
- START while BUSY=1 is ignored; no queueing. START in the DONE cycle is ignored. A new read begins only on a START sampled in IDLE.
- After FINISH, TCK rests low and TMS rests 0, keeping the target in Run-Test/Idle, until the next START or reset.
- ID/ID_VALID hold their value between reads and are overwritten only at DONE.
- TDO stuck at 0 gives ID=0, ID_VALID=0, with normal DONE timing. The block has no timeout and no error state.

Test Plan:
- Reset values: assert RST mid-idle → TCK=0, TMS=1, TDI=1, ID=0, ID_VALID=0, BUSY=0, DONE=0 immediately, without waiting for a CLK edge.
- Defaults with a behavioural TAP model returning IDCODE 8'hAB: START pulse → 19 TCK rising edges, TMS pattern 1,1,1,1,1,0,1,0,0,0,0,0,0,0,0,0,1,1,0. DONE at cycle 77 after START; ID=8'hAB, ID_VALID=1.
- Same model with IDCODE 8'h54 and HALF_PERIOD=1: ID=8'h54, ID_VALID=0. DONE at cycle 39. TCK toggles every CLK cycle.
- ID_WIDTH=32, target ID 32'hABCD12FF: ID=32'hABCD12FF, ID_VALID=1. Exactly 43 TCK periods.
- Extra START pulses at cycles 10 and 77 (the DONE cycle) during a read: ignored, exactly one sequence and one DONE pulse. A START at cycle 79 starts a second read, and ID holds 8'hAB until that read's DONE.
- RST asserted at cycle 40 of a read, then released, then START: the first read produces no DONE and ID stays 0. The second read completes normally with ID=8'hAB.

Source files
------------

// File: rtl/jtag_id_reader.sv
// rtl/jtag_id_reader.sv - JTAG host that walks a TAP into Shift-DR and reads the ID register.
module jtag_id_reader #(
  parameter int ID_WIDTH    = 8,
  parameter int HALF_PERIOD = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                TDO,
  output logic                TCK,
  output logic                TMS,
  output logic                TDI,
  output logic [ID_WIDTH-1:0] ID,
  output logic                ID_VALID,
  output logic                BUSY,
  output logic                DONE
);

  localparam int N  = 11 + ID_WIDTH;
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int PW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t              state;
  logic [HW-1:0]       half_cnt;
  logic [PW-1:0]       period;
  logic [ID_WIDTH-1:0] shreg;

  // TMS value presented for 1-based TCK rising edge p+1; zero past the end keeps Run-Test/Idle.
  function automatic logic tms_for(input logic [PW-1:0] p);
    int k;
    k = int'(p) + 1;
    return (k <= 5) || (k == 7) || (k == 9 + ID_WIDTH) || (k == 10 + ID_WIDTH);
  endfunction

  function automatic logic shift_edge(input logic [PW-1:0] p);
    int k;
    k = int'(p) + 1;
    return (k >= 10) && (k <= 9 + ID_WIDTH);
  endfunction

  assign TDI = 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      half_cnt <= '0;
      period   <= '0;
      shreg    <= '0;
      TCK      <= 1'b0;
      TMS      <= 1'b1;
      ID       <= '0;
      ID_VALID <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          // A START overlapping the DONE pulse is dropped rather than queued.
          if (START && !DONE) begin
            state    <= RUN;
            BUSY     <= 1'b1;
            TCK      <= 1'b0;
            TMS      <= tms_for('0);
            half_cnt <= '0;
            period   <= '0;
          end
        end
        RUN: begin
          if (half_cnt == HW'(HALF_PERIOD - 1)) begin
            half_cnt <= '0;
            if (!TCK) begin
              TCK <= 1'b1;
              if (shift_edge(period)) begin
                shreg <= {TDO, shreg[ID_WIDTH-1:1]};
              end
            end else begin
              TCK <= 1'b0;
              TMS <= tms_for(period + 1'b1);
              if (period == PW'(N - 1)) begin
                state <= FINISH;
              end else begin
                period <= period + 1'b1;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        FINISH: begin
          ID       <= shreg;
          ID_VALID <= shreg[0];
          DONE     <= 1'b1;
          BUSY     <= 1'b0;
          period   <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_id_reader.sv
// tb/tb_jtag_id_reader.sv - directed bench for jtag_id_reader with behavioural TAP targets.
module tb_jtag_id_reader;

  localparam logic [2:0] TLR = 3'd0, RTI = 3'd1, SEL = 3'd2, CAP = 3'd3,
                         SH  = 3'd4, EX1 = 3'd5, UPD = 3'd6;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, start_c;
  logic tdo_a = 1'b1, tdo_b = 1'b1, tdo_c = 1'b1;
  logic tck_a, tms_a, tdi_a, valid_a, busy_a, done_a;
  logic tck_b, tms_b, tdi_b, valid_b, busy_b, done_b;
  logic tck_c, tms_c, tdi_c, valid_c, busy_c, done_c;
  logic [7:0]  id_a, id_b;
  logic [31:0] id_c;
  logic [31:0] tgt_a, tgt_b, tgt_c;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  jtag_id_reader #(.ID_WIDTH(8), .HALF_PERIOD(2)) dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .TDO(tdo_a), .TCK(tck_a), .TMS(tms_a),
    .TDI(tdi_a), .ID(id_a), .ID_VALID(valid_a), .BUSY(busy_a), .DONE(done_a));

  jtag_id_reader #(.ID_WIDTH(8), .HALF_PERIOD(1)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .TDO(tdo_b), .TCK(tck_b), .TMS(tms_b),
    .TDI(tdi_b), .ID(id_b), .ID_VALID(valid_b), .BUSY(busy_b), .DONE(done_b));

  jtag_id_reader #(.ID_WIDTH(32), .HALF_PERIOD(2)) dut_c (
    .CLK(clk), .RST(rst), .START(start_c), .TDO(tdo_c), .TCK(tck_c), .TMS(tms_c),
    .TDI(tdi_c), .ID(id_c), .ID_VALID(valid_c), .BUSY(busy_c), .DONE(done_c));

  // TAP targets: capture on Capture-DR rise, shift on Shift-DR rise, drive TDO on fall.
  function automatic logic [2:0] tap_next(input logic [2:0] s, input logic t);
    case (s)
      TLR:     return t ? TLR : RTI;
      RTI:     return t ? SEL : RTI;
      SEL:     return t ? TLR : CAP;
      CAP:     return t ? EX1 : SH;
      SH:      return t ? EX1 : SH;
      EX1:     return t ? UPD : SH;
      UPD:     return t ? SEL : RTI;
      default: return TLR;
    endcase
  endfunction

  logic [2:0]  st_a = TLR, st_b = TLR, st_c = TLR;
  logic [31:0] sr_a = '0, sr_b = '0, sr_c = '0;
  logic [63:0] tlog_a = '0;
  int rises_a = 0, rises_b = 0, rises_c = 0;

  always @(posedge tck_a) begin
    if (st_a == CAP) sr_a = tgt_a; else if (st_a == SH) sr_a = sr_a >> 1;
    st_a = tap_next(st_a, tms_a);
    tlog_a = {tlog_a[62:0], tms_a};
    rises_a++;
  end
  always @(negedge tck_a) tdo_a = (st_a == SH) ? sr_a[0] : 1'b1;

  always @(posedge tck_b) begin
    if (st_b == CAP) sr_b = tgt_b; else if (st_b == SH) sr_b = sr_b >> 1;
    st_b = tap_next(st_b, tms_b);
    rises_b++;
  end
  always @(negedge tck_b) tdo_b = (st_b == SH) ? sr_b[0] : 1'b1;

  always @(posedge tck_c) begin
    if (st_c == CAP) sr_c = tgt_c; else if (st_c == SH) sr_c = sr_c >> 1;
    st_c = tap_next(st_c, tms_c);
    rises_c++;
  end
  always @(negedge tck_c) tdo_c = (st_c == SH) ? sr_c[0] : 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int base, ndone, first_done, second_done, ndone_early, r1, tog_err;
    logic [18:0] tlog1;
    logic [7:0]  id_first, id_second, id_mid;
    logic        valid_first, valid_second, tms_rest, tck_rest;
    logic [31:0] id_wide;
    logic        valid_wide;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    tgt_a = 32'hAB; tgt_b = 32'h54; tgt_c = 32'hABCD12FF;
    repeat (2) @(negedge clk);
    check("rst_tck", tck_a, 1'b0);
    check("rst_tms", tms_a, 1'b1);
    check("rst_tdi", tdi_a, 1'b1);
    check("rst_id", id_a, 8'h00);
    check("rst_valid", valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Default read with stray STARTs at cycles 10 and 77, second read at 79
    base = rises_a; ndone = 0; first_done = -1; second_done = -1; ndone_early = -1;
    r1 = -1; tlog1 = '0; id_first = '0; id_second = '0; id_mid = '0;
    valid_first = 1'bx; valid_second = 1'bx; tms_rest = 1'bx; tck_rest = 1'bx;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a_busy_c0", busy_a, 1'b1);
    check("a_tms_c0", tms_a, 1'b1);
    for (int k = 1; k <= 160; k++) begin
      start_a = (k == 10) || (k == 77) || (k == 79);
      @(negedge clk);
      if (done_a) begin
        ndone++;
        if (ndone == 1) begin
          first_done = k; id_first = id_a; valid_first = valid_a;
        end else begin
          second_done = k; id_second = id_a; valid_second = valid_a;
        end
      end
      if (k == 78) begin
        ndone_early = ndone; r1 = rises_a - base; tlog1 = tlog_a[18:0];
        tms_rest = tms_a; tck_rest = tck_a; tgt_a = 32'h3C;
      end
      if (k == 120) id_mid = id_a;
    end
    start_a = 1'b0;
    check("a_done_cycle", first_done, 77);
    check("a_id", id_first, 8'hAB);
    check("a_valid", valid_first, 1'b1);
    check("a_one_done", ndone_early, 1);
    check("a_tck_rises", r1, 19);
    check("a_tms_pattern", tlog1, 19'b1111101000000000110);
    check("a_tms_rest", tms_rest, 1'b0);
    check("a_tck_rest", tck_rest, 1'b0);
    check("a_tdi", tdi_a, 1'b1);
    check("a_id_hold", id_mid, 8'hAB);
    check("a2_done_cycle", second_done, 156);
    check("a2_id", id_second, 8'h3C);
    check("a2_valid", valid_second, 1'b0);
    check("a_total_done", ndone, 2);

    // Reset in the middle of a read
    tgt_a = 32'hAB;
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_tck", tck_a, 1'b0);
    check("mid_rst_tms", tms_a, 1'b1);
    check("mid_rst_tdi", tdi_a, 1'b1);
    check("mid_rst_id", id_a, 8'h00);
    check("mid_rst_valid", valid_a, 1'b0);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_done", done_a, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    check("mid_rst_id_held", id_a, 8'h00);
    first_done = -1; id_first = '0; valid_first = 1'bx;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (done_a && first_done < 0) begin
        first_done = k; id_first = id_a; valid_first = valid_a;
      end
    end
    check("post_rst_done_cycle", first_done, 77);
    check("post_rst_id", id_first, 8'hAB);
    check("post_rst_valid", valid_first, 1'b1);

    // HALF_PERIOD=1, IDCODE 8'h54
    base = rises_b; first_done = -1; id_first = '0; valid_first = 1'bx; tog_err = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k <= 38 && tck_b !== ((k % 2) == 1)) tog_err++;
      if (done_b && first_done < 0) begin
        first_done = k; id_first = id_b; valid_first = valid_b;
      end
    end
    check("b_done_cycle", first_done, 39);
    check("b_id", id_first, 8'h54);
    check("b_valid", valid_first, 1'b0);
    check("b_tck_toggle_errs", tog_err, 0);
    check("b_tck_rises", rises_b - base, 19);

    // ID_WIDTH=32
    base = rises_c; first_done = -1; id_wide = '0; valid_wide = 1'bx;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done_c && first_done < 0) begin
        first_done = k; id_wide = id_c; valid_wide = valid_c;
      end
    end
    check("c_done_cycle", first_done, 173);
    check("c_id", id_wide, 32'hABCD12FF);
    check("c_valid", valid_wide, 1'b1);
    check("c_tck_rises", rises_c - base, 43);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
